// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: instruction field widths, opcodes and
// the fetch/decode controller state encoding.
package cpu_pkg;

    localparam int IW      = 16;  // instruction word, fetched as two ROM bytes
    localparam int AW_DEF  = 13;
    localparam int OPW_DEF = 3;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        FETCH_HI,
        FETCH_LO,
        DECODE,
        SKIP1,
        SKIP2,
        EXEC,
        HALT
    } state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// ROM fetch watchdog: counts consecutive cycles of an unanswered rom_rd and
// flags expiry once the count reaches TIMEOUT_CYC.
module fetch_watchdog #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clock,
    input  logic rst,
    input  logic waiting,
    output logic expired
);

    localparam logic [3:0] LIMIT = 4'(TIMEOUT_CYC);

    logic [3:0] cnt;

    // Saturates at LIMIT so expiry stays asserted until the request goes away.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!waiting) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch/decode controller: fetches 16-bit instructions as two ROM
// bytes, runs HLT/SKZ/JMP itself and hands datapath ops off via exec_valid/
// exec_done. Optional ROM-ack timeout is built when FETCH_TIMEOUT_EN is defined.
module instr_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int OPW         = OPW_DEF,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic           clock,
    input  logic           rst,
    input  logic [7:0]     rom_data,
    input  logic           rom_ack,
    output logic           rom_rd,
    output logic           pc_inc,
    output logic           load_pc,
    output logic [AW-1:0]  ir_addr,
    output logic [OPW-1:0] opcode,
    input  logic           zero_flag,
    output logic           exec_valid,
    input  logic           exec_done,
    output logic           halted,
    output logic           fetch_err
);

    if (AW + OPW != IW) begin : g_bad_fields
        $error("AW + OPW must equal the instruction width");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit the 4-bit wait counter");
    end

    state_e        state;
    logic [IW-1:0] ir;
    logic          accept;
    logic          timeout;

    // An ack only counts while a request is actually outstanding.
    assign accept  = rom_rd & rom_ack;
    assign ir_addr = ir[AW-1:0];
    assign opcode  = ir[AW +: OPW];

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clock   (clock),
        .rst     (rst),
        .waiting (rom_rd & ~rom_ack),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // NOTE: state and every output register use <= so all of them update
    // together from the values present before the clock edge.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= FETCH_HI;
            ir         <= '0;
            rom_rd     <= 1'b0;
            pc_inc     <= 1'b0;
            load_pc    <= 1'b0;
            exec_valid <= 1'b0;
            halted     <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            pc_inc  <= 1'b0;
            load_pc <= 1'b0;
            case (state)
                FETCH_HI, FETCH_LO: begin
                    if (accept) begin
                        pc_inc <= 1'b1;
                        if (state == FETCH_HI) begin
                            ir[IW-1:8] <= rom_data;
                            state      <= FETCH_LO;
                        end else begin
                            ir[7:0] <= rom_data;
                            rom_rd  <= 1'b0;
                            state   <= DECODE;
                        end
                    end else if (timeout) begin
                        rom_rd    <= 1'b0;
                        halted    <= 1'b1;
                        fetch_err <= 1'b1;
                        state     <= HALT;
                    end else begin
                        rom_rd <= 1'b1;
                    end
                end
                DECODE: begin
                    case (opcode_e'(opcode))
                        OP_HLT: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        OP_JMP: begin
                            load_pc <= 1'b1;
                            rom_rd  <= 1'b1;
                            state   <= FETCH_HI;
                        end
                        OP_SKZ: begin
                            if (zero_flag) begin
                                pc_inc <= 1'b1;
                                state  <= SKIP1;
                            end else begin
                                rom_rd <= 1'b1;
                                state  <= FETCH_HI;
                            end
                        end
                        default: begin
                            exec_valid <= 1'b1;
                            state      <= EXEC;
                        end
                    endcase
                end
                // The two skip cycles each carry one pc_inc, stepping over a
                // whole 2-byte instruction.
                SKIP1: begin
                    pc_inc <= 1'b1;
                    state  <= SKIP2;
                end
                SKIP2: begin
                    rom_rd <= 1'b1;
                    state  <= FETCH_HI;
                end
                EXEC: begin
                    if (exec_done) begin
                        exec_valid <= 1'b0;
                        rom_rd     <= 1'b1;
                        state      <= FETCH_HI;
                    end
                end
                HALT: begin
                end
                default: begin
                    state <= FETCH_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized scoreboard bench for instr_fetch_ctrl: an ISA-level model predicts
// each instruction's fetch addresses, decode fields, exec length and refetch gap.
module tb_instr_fetch_ctrl;

    logic        clock = 1'b0;
    logic        rst;
    logic [7:0]  rom_data;
    logic        rom_ack;
    logic        rom_rd;
    logic        pc_inc;
    logic        load_pc;
    logic [12:0] ir_addr;
    logic [2:0]  opcode;
    logic        zero_flag;
    logic        exec_valid;
    logic        exec_done;
    logic        halted;
    logic        fetch_err;

    instr_fetch_ctrl dut (
        .clock      (clock),
        .rst        (rst),
        .rom_data   (rom_data),
        .rom_ack    (rom_ack),
        .rom_rd     (rom_rd),
        .pc_inc     (pc_inc),
        .load_pc    (load_pc),
        .ir_addr    (ir_addr),
        .opcode     (opcode),
        .zero_flag  (zero_flag),
        .exec_valid (exec_valid),
        .exec_done  (exec_done),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int op;
        int addr;
        int pc;        // address of the instruction's high byte
        int exec_cyc;  // cycles exec_valid must stay high
        int gap;       // cycles from DECODE to the next rom_rd rise (-1: never)
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   ref_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: an instruction's effect on the program counter and timing.
    function automatic bit is_datapath(input int op);
        return op >= 2 && op <= 6;
    endfunction

    function automatic int next_pc(input int pc, input int op, input int addr, input bit z);
        if (op == 7) return addr;
        if (op == 1 && z) return (pc + 4) % 8192;
        return (pc + 2) % 8192;
    endfunction

    function automatic int refetch_gap(input int op, input bit z, input int n);
        if (op == 0) return -1;
        if (op == 1 && z) return 3;
        if (is_datapath(op)) return n + 1;
        return 1;
    endfunction

    task automatic fetch_byte(input logic [7:0] b, input int maxw);
        int guard = 0;
        while (!rom_rd && guard < 64) begin
            rom_ack   = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            rom_data  = 8'($urandom);
            tick();
            guard++;
        end
        if (!rom_rd) check("rom_rd_wait_timeout", rom_rd, 1);
        rom_ack = 1'b0;
        repeat ($urandom_range(0, maxw)) begin
            exec_done = 1'($urandom_range(0, 1));
            rom_data  = 8'($urandom);
            tick();
        end
        rom_ack   = 1'b1;
        rom_data  = b;
        exec_done = 1'($urandom_range(0, 1));
        tick();
        rom_ack   = 1'b0;
        exec_done = 1'b0;
    endtask

    task automatic run_exec(input int n);
        int seen  = 0;
        int guard = 0;
        while (seen < n && guard < 64) begin
            if (exec_valid) seen++;
            exec_done = (seen == n);
            rom_ack   = (seen != n) && ($urandom_range(0, 1) == 1);
            rom_data  = 8'($urandom);
            tick();
            guard++;
        end
        exec_done = 1'b0;
        rom_ack   = 1'b0;
        if (seen < n) check("exec_valid_wait_timeout", seen, n);
    endtask

    task automatic do_instr(input int op, input int addr, input bit z, input int n, input int maxw);
        exp_t        e;
        logic [15:0] word;
        e.op       = op;
        e.addr     = addr;
        e.pc       = ref_pc;
        e.exec_cyc = is_datapath(op) ? n : 0;
        e.gap      = refetch_gap(op, z, n);
        exp_q.push_back(e);
        ref_pc     = next_pc(ref_pc, op, addr, z);
        word       = {3'(op), 13'(addr)};
        zero_flag  = z;
        fetch_byte(word[15:8], maxw);
        fetch_byte(word[7:0], maxw);
        rom_ack   = 1'($urandom_range(0, 1));
        exec_done = 1'($urandom_range(0, 1));
        tick();
        rom_ack   = 1'b0;
        exec_done = 1'b0;
        zero_flag = 1'($urandom_range(0, 1));
        if (is_datapath(op)) run_exec(n);
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_ctrl_outputs"},
              {26'd0, rom_rd, pc_inc, load_pc, exec_valid, halted, fetch_err}, 0);
        check({tag, "_ir_fields"}, {16'd0, opcode, ir_addr}, 0);
    endtask

    // Monitor: follows the DUT like the program counter would and scores every
    // fetch, decode and refetch against the queued expectations.
    initial begin : monitor
        exp_t        cur;
        bit          have_cur = 0;
        bit          dec_pend = 0;
        bit          gap_pend = 0;
        int          dec_cyc  = 0;
        int          ev_cnt   = 0;
        int          bytes    = 0;
        logic [12:0] mon_pc   = '0;
        logic        rd_prev  = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (rst !== 1'b1) begin
                exp_q.delete();
                have_cur = 0; dec_pend = 0; gap_pend = 0;
                ev_cnt = 0; bytes = 0; mon_pc = '0; rd_prev = 1'b0;
                continue;
            end
            if (pc_inc || load_pc) check("pc_inc_load_pc_exclusive", pc_inc & load_pc, 0);
            if (load_pc) mon_pc = ir_addr;
            else if (pc_inc) mon_pc = mon_pc + 13'd1;

            if (dec_pend) begin
                dec_pend = 0;
                if (exp_q.size() == 0) begin
                    check("decode_without_expectation", exp_q.size(), 1);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    check("decode_opcode", opcode, cur.op);
                    check("decode_ir_addr", ir_addr, cur.addr);
                    check("decode_rd_halted", {rom_rd, halted}, 0);
                    dec_cyc  = cyc;
                    gap_pend = (cur.gap >= 0);
                    ev_cnt   = 0;
                end
            end else if (gap_pend && rom_rd && !rd_prev) begin
                gap_pend = 0;
                check("refetch_gap", cyc - dec_cyc, cur.gap);
                check("exec_valid_cycles", ev_cnt, cur.exec_cyc);
            end
            if (exec_valid) ev_cnt++;

            if (have_cur && cur.op == 0 && cyc > dec_cyc)
                check("halt_state", {halted, rom_rd, exec_valid}, 3'b100);

            if (rom_rd && rom_ack) begin
                if (exp_q.size() == 0) begin
                    check("fetch_without_expectation", exp_q.size(), 1);
                end else if (bytes % 2 == 0) begin
                    check("fetch_hi_pc", mon_pc, exp_q[0].pc);
                end else begin
                    check("fetch_lo_pc", mon_pc, (exp_q[0].pc + 1) % 8192);
                    dec_pend = 1;
                end
                bytes++;
            end
            rd_prev = rom_rd;
        end
    end

    initial begin : safety
        #300000;
        $display("FAIL global_time_limit: simulation did not end, n_bad=%0d", n_bad);
        $fatal(1, "time limit");
    end

    initial begin : driver
        rst = 1'b0; rom_ack = 1'b0; rom_data = '0; zero_flag = 1'b0; exec_done = 1'b0;
        #1;
        check_all_reset("reset");
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b1;
        ref_pc = 0;
        check("rom_rd_before_first_edge", rom_rd, 0);
        tick();
        check("rom_rd_after_first_edge", rom_rd, 1);

        do_instr(7, 13'h0025, 1'b0, 0, 0);  // E0 25: JMP 0x0025
        do_instr(1, 0, 1'b1, 0, 0);         // 20 00: SKZ taken
        do_instr(1, 0, 1'b0, 0, 0);         // 20 00: SKZ not taken
        do_instr(2, 13'h0010, 1'b0, 4, 0);  // 40 10: ADD, 4-cycle exec

        for (int i = 0; i < 120; i++) begin
            do_instr($urandom_range(1, 7), $urandom_range(0, 8191),
                     1'($urandom_range(0, 1)), $urandom_range(1, 5), $urandom_range(0, 2));
        end

        do_instr(0, $urandom_range(0, 8191), 1'b0, 0, 1);  // HLT
        repeat (12) begin
            rom_ack   = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            rom_data  = 8'($urandom);
            tick();
        end
        rom_ack = 1'b0; exec_done = 1'b0;

        rst = 1'b0;
        #1;
        check_all_reset("reset_in_halt");
        tick();
        rst = 1'b1;
        ref_pc = 0;

        // Partial fetch interrupted by reset: the half-loaded ir must vanish.
        do_instr(3, 13'h1ABC, 1'b0, 2, 0);
        begin
            exp_t e;
            e.op = 5; e.addr = 13'h0512; e.pc = ref_pc; e.exec_cyc = 1; e.gap = 2;
            exp_q.push_back(e);
            fetch_byte(8'hA5, 0);
        end
        rst = 1'b0;
        #1;
        check_all_reset("reset_mid_fetch");
        tick();
        rst = 1'b1;
        ref_pc = 0;
        for (int i = 0; i < 4; i++) begin
            do_instr($urandom_range(1, 7), $urandom_range(0, 8191),
                     1'($urandom_range(0, 1)), $urandom_range(1, 3), 1);
        end
        repeat (6) tick();

        // ROM never answers.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rom_ack = 1'b0;
        repeat (40) tick();
`ifdef FETCH_TIMEOUT_EN
        check("timeout_fetch_err", fetch_err, 1);
        check("timeout_halted", {halted, rom_rd}, 2'b10);
`else
        check("no_timeout_fetch_err", fetch_err, 0);
        check("no_timeout_waiting", {halted, rom_rd}, 2'b01);
`endif

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
